// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and threshold defaults for the sync_fifo_v2 family.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package sync_fifo_pkg;

    // Default almost_empty threshold: flag while at most one word remains.
    localparam int AE_THRESH_DEF = 1;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: indexes 0..depth-1, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Default almost_full threshold: one slot short of full.
    function automatic int af_thresh_def(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Bundles the sync_fifo_v2 write/read handshake, control and status signals.
// Latency: n/a (wiring only).
// Backpressure: producer must watch full; consumer must watch empty/out_valid.
// Ports: master = user side (drives push/data/pop/flush/clr_err),
//        slave  = FIFO side (drives out/out_valid/flags/level/errors).
interface sync_fifo_v2_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = lvl_w(DEPTH);

    logic             flush;
    logic             push;
    logic [WIDTH-1:0] data;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, data, pop, clr_err,
        input  out, out_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  flush, push, data, pop, clr_err,
        output out, out_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage array: one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the owner gates wr_en and keeps addresses in range.
// Ports: clk, wr_en/wr_addr/wr_dat (write), rd_addr -> rd_dat (combinational read).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, arbitrary depth, thresholds, level, flush, sticky errors.
// Latency: registered read port = 1 cycle; with FIFO_FWFT_EN head word shown with 0 cycles.
// Backpressure: push while full / pop while empty are dropped and flagged sticky.
// Ports: clk, rst (sync, active-high), bus (sync_fifo_v2_if.slave).
// Build option: define FIFO_FWFT_EN for the first-word-fall-through read port.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = af_thresh_def(DEPTH),
    parameter int AE_THRESH = AE_THRESH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_v2_if.slave bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] rd_dat;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic             wr_en;
    logic             overflow;
    logic             underflow;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    // Acceptance uses pre-edge state only: a pop cannot make room for a
    // same-cycle push, and a push cannot feed a same-cycle pop.
    assign push_ok = bus.push & ~full;
    assign pop_ok  = bus.pop & ~empty;
    assign wr_en   = push_ok & ~bus.flush & ~rst;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_dat  (bus.data),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags: survive flush, a new violation beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!bus.flush && bus.push && full) overflow <= 1'b1;
            else if (bus.clr_err)               overflow <= 1'b0;
            if (!bus.flush && bus.pop && empty) underflow <= 1'b1;
            else if (bus.clr_err)               underflow <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry shown directly; zeroed when nothing is stored.
    assign bus.out       = empty ? '0 : rd_dat;
    assign bus.out_valid = ~empty;
`else
    logic [WIDTH-1:0] out_q;
    logic             out_vld_q;

    // out_valid pulses for one cycle per accepted pop; out holds otherwise.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= pop_ok;
            if (pop_ok) out_q <= rd_dat;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_vld_q;
`endif

    assign bus.level        = level;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (int'(level) >= AF_THRESH);
    assign bus.almost_empty = (int'(level) <= AE_THRESH);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2 (WIDTH=8, DEPTH=5, AF=4, AE=1) with a queue model.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: exercises overflow/underflow rejection and flag stickiness.
module tb_sync_fifo_v2;
    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic clk;
    logic rst;

    sync_fifo_v2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fif ();

    sync_fifo_v2 #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif.slave)
    );

    always #5 clk = ~clk;

    int   n_run;
    int   n_fail;
    string step;

    logic [7:0] mdl [$];   // model FIFO contents
    logic [7:0] sb  [$];   // popped words awaiting the registered read port
    logic       m_ovf;
    logic       m_udf;
    logic       exp_vld;
    logic [7:0] exp_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",        32'(fif.level),  32'(mdl.size()));
        chk("empty",        32'(fif.empty),  32'(mdl.size() == 0));
        chk("full",         32'(fif.full),   32'(mdl.size() == DEPTH));
        chk("almost_full",  32'(fif.almost_full),  32'(mdl.size() >= AF));
        chk("almost_empty", 32'(fif.almost_empty), 32'(mdl.size() <= AE));
        chk("overflow",     32'(fif.overflow),  32'(m_ovf));
        chk("underflow",    32'(fif.underflow), 32'(m_udf));
        chk("out_valid",    32'(fif.out_valid), 32'(exp_vld));
        chk("out",          32'(fif.out),       32'(exp_out));
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 ns later.
    task automatic cyc(input logic p, input logic [7:0] d, input logic pp,
                       input logic f = 1'b0, input logic ce = 1'b0, input logic r = 1'b0);
        logic m_full, m_empty, pok, wok;
        logic [7:0] head;
        rst         = r;
        fif.push    = p;
        fif.data    = d;
        fif.pop     = pp;
        fif.flush   = f;
        fif.clr_err = ce;
        @(posedge clk);
        m_full  = (mdl.size() == DEPTH);
        m_empty = (mdl.size() == 0);
        if (r) begin
            mdl.delete(); sb.delete();
            m_ovf = 1'b0; m_udf = 1'b0; exp_vld = 1'b0; exp_out = '0;
        end else if (f) begin
            mdl.delete(); sb.delete();
            exp_vld = 1'b0; exp_out = '0;
            if (ce) begin m_ovf = 1'b0; m_udf = 1'b0; end
        end else begin
            pok = pp && !m_empty;
            wok = p && !m_full;
            if (p && m_full) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
            if (pp && m_empty) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
            if (pok) begin
                head = mdl.pop_front();
                sb.push_back(head);
            end
            if (wok) mdl.push_back(d);
`ifndef FIFO_FWFT_EN
            exp_vld = pok;
            if (pok) exp_out = sb.pop_front();
`endif
        end
`ifdef FIFO_FWFT_EN
        sb.delete();
        exp_vld = (mdl.size() != 0);
        exp_out = (mdl.size() != 0) ? mdl[0] : 8'h00;
`endif
        #1;
        check_all();
    endtask

    initial begin
        clk = 1'b0;
        n_run = 0; n_fail = 0;
        m_ovf = 1'b0; m_udf = 1'b0; exp_vld = 1'b0; exp_out = '0;
        rst = 1'b1;
        fif.push = 1'b0; fif.data = '0; fif.pop = 1'b0;
        fif.flush = 1'b0; fif.clr_err = 1'b0;

        step = "reset";
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0);

        step = "fill";
        for (int i = 0; i < 5; i++) cyc(1, 8'h11 + 8'(i), 0);
        step = "overflow";
        cyc(1, 8'h16, 0);

        step = "drain";
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1);
        step = "underflow";
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        step = "set_beats_clr";
        cyc(0, 8'h00, 1, 0, 1);
        step = "clr_err";
        cyc(0, 8'h00, 0, 0, 1);

        step = "wrap";
        for (int i = 0; i < 3; i++) cyc(1, 8'h21 + 8'(i), 0);
        for (int i = 0; i < 7; i++) cyc(1, 8'h30 + 8'(i), 1);
        cyc(0, 8'h00, 0);

        step = "full_pushpop";
        cyc(1, 8'h40, 0);
        cyc(1, 8'h41, 0);
        cyc(1, 8'h42, 1);
        cyc(0, 8'h00, 0);

        step = "flush";
        cyc(0, 8'h00, 1);
        cyc(1, 8'h50, 1, 1);
        cyc(0, 8'h00, 0);
        step = "flush_clr";
        cyc(0, 8'h00, 0, 0, 1);

        step = "rst_mid";
        cyc(1, 8'h61, 0);
        cyc(1, 8'h62, 0);
        cyc(0, 8'h00, 1, 0, 0, 1);
        cyc(0, 8'h00, 0);

        step = "single_word";
        cyc(1, 8'hA5, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
